// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit queue.
// Holds the launch FSM state enum and sizing constants.
package uart_pkg;

  localparam int UART_BYTE_W     = 8;
  localparam int TXQ_DEPTH       = 16;
  localparam int TXQ_AE_THRESH   = 4;
  localparam int TXQ_ACK_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered full/empty/level.
// Ports: push/wr_data in, pop/rd_data out (head, comb), flush,
// full, empty, level, level_next (fill after this edge).
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = TXQ_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [LW-1:0]          level,
  output logic [LW-1:0]          level_next
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   push_ok;
  logic                   pop_ok;

  // Flush wins over both push and pop in its cycle.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else if (push_ok && !pop_ok) begin
      level_next = level + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_next = level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
      full  <= (level_next == FULL_LVL);
      empty <= (level_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter; launches one byte per
// tx_busy cycle with an ack timeout. Ports: wr_en/wr_data push,
// flush, ovf_clr, tx_busy in; tx_start/tx_data to the core;
// full/empty/level/almost_empty status; overflow/ack_err sticky.
// almost_empty compare is built only with UART_TXQ_AE_IRQ_EN.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH       = TXQ_DEPTH,
  parameter int AE_THRESH   = TXQ_AE_THRESH,
  parameter int ACK_TIMEOUT = TXQ_ACK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [UART_BYTE_W-1:0]  wr_data,
  input  logic                    flush,
  input  logic                    ovf_clr,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [UART_BYTE_W-1:0]  tx_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    ack_err
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LD = CW'(ACK_TIMEOUT);

  txq_state_t             state;
  txq_state_t             state_nxt;
  logic [CW-1:0]          cnt;
  logic                   pop;
  logic                   pop_go;
  logic                   timeout;
  logic [UART_BYTE_W-1:0] head;
  logic [LW-1:0]          level_next;

  assign pop     = (state == IDLE) & ~empty & ~tx_busy;
  assign pop_go  = pop & ~flush;
  assign timeout = (state == WAIT_BUSY) & ~tx_busy
                 & (cnt == CW'(1));

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (wr_en),
    .wr_data    (wr_data),
    .pop        (pop),
    .flush      (flush),
    .rd_data    (head),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .level_next (level_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (pop_go) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_nxt = WAIT_DONE;
        else if (timeout) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state == LAUNCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == LAUNCH) begin
      cnt <= TMO_LD;
    end else if (state == WAIT_BUSY && !tx_busy) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tx_data <= '0;
    else if (pop_go) tx_data <= head;
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      overflow <= (wr_en & full & ~flush)
                | (overflow & ~ovf_clr);
      ack_err  <= timeout | (ack_err & ~ovf_clr);
    end
  end

`ifdef UART_TXQ_AE_IRQ_EN
  localparam logic [LW-1:0] AE_LVL = LW'(AE_THRESH);

  // Compare on the upcoming fill so the flag moves with level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) almost_empty <= (AE_THRESH >= 0);
    else        almost_empty <= (level_next <= AE_LVL);
  end
`else
  logic unused_level_next;
  assign unused_level_next = ^level_next;
  assign almost_empty      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple core model.
// Covers latency, pacing, overflow, timeout, flush, AE, reset.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AE    = 4;
  localparam int TMO   = 255;
`ifdef UART_TXQ_AE_IRQ_EN
  localparam bit AE_ON = 1'b1;
`else
  localparam bit AE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       force_busy = 1'b0;
  logic       core_en = 1'b1;
  logic       core_busy = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       almost_empty;
  logic       overflow;
  logic       ack_err;

  int checks = 0;
  int errors = 0;
  int launches = 0;
  int hold = 3;
  int core_cnt = 0;

  always #5 clk = ~clk;

  assign tx_busy = core_busy | force_busy;

  uart_tx_queue #(
    .DEPTH       (DEPTH),
    .AE_THRESH   (AE),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .ovf_clr      (ovf_clr),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .ack_err      (ack_err)
  );

  // Core model: busy for `hold` cycles after each accepted start.
  always @(posedge clk) begin
    if (tx_start) launches <= launches + 1;
    if (core_en && tx_start) begin
      core_busy <= 1'b1;
      core_cnt  <= hold;
    end else if (core_busy) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_busy <= 1'b0;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_start(output bit ok, output int idle);
    ok   = 1'b0;
    idle = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (tx_busy) idle = 0;
      else         idle++;
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int idle;
    int base;
    int n;
    logic [7:0] exp3 [3];
    exp3[0] = 8'h11;
    exp3[1] = 8'h22;
    exp3[2] = 8'h33;

    // Reset state
    repeat (3) tick();
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_ae", almost_empty, AE_ON);
    check("rst_ovf", overflow, 0);
    check("rst_ackerr", ack_err, 0);
    rst_n = 1'b1;
    tick();

    // Write-to-launch latency
    hold = 3;
    push(8'hA5);
    check("lat_n_start", tx_start, 0);
    check("lat_n_level", level, 1);
    tick();
    check("lat_start", tx_start, 1);
    check("lat_data", tx_data, 8'hA5);
    check("lat_empty", empty, 1);
    repeat (10) tick();
    check("lat_count", launches, 1);

    // Three bytes paced by a slow core
    hold = 100;
    force_busy = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("b2b_level3", level, 3);
    force_busy = 1'b0;
    base = launches;
    for (int i = 0; i < 3; i++) begin
      wait_start(ok, idle);
      check("b2b_seen", ok, 1);
      check("b2b_data", tx_data, exp3[i]);
      check("b2b_level", level, 2 - i);
      check("b2b_gap", idle >= 1, 1);
    end
    repeat (120) tick();
    check("b2b_count", launches - base, 3);

    // Overflow: 17 pushes into 16 entries
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    check("ovf_full", full, 1);
    check("ovf_pre", overflow, 0);
    check("ovf_lvl16", level, 16);
    push(8'h50);
    check("ovf_set", overflow, 1);
    check("ovf_lvl_sat", level, 16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    hold = 2;
    base = launches;
    force_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_start(ok, idle);
      check("ovf_seen", ok, 1);
      check("ovf_data", tx_data, 8'h40 + 8'(i));
    end
    repeat (30) tick();
    check("ovf_count", launches - base, 16);
    check("ovf_empty", empty, 1);

    // Ack timeout: core ignores the launch
    core_en = 1'b0;
    push(8'h77);
    wait_start(ok, idle);
    check("tmo_seen", ok, 1);
    check("tmo_data", tx_data, 8'h77);
    push(8'h88);
    n = 1;
    while (!ack_err && n < TMO + 20) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, TMO + 1);
    check("tmo_ackerr", ack_err, 1);
    core_en = 1'b1;
    wait_start(ok, idle);
    check("tmo_next", ok, 1);
    check("tmo_next_data", tx_data, 8'h88);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("tmo_clr", ack_err, 0);
    repeat (10) tick();

    // Flush + write during WAIT_DONE
    hold = 100;
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    force_busy = 1'b0;
    wait_start(ok, idle);
    check("fl_data", tx_data, 8'h60);
    check("fl_level5", level, 5);
    repeat (3) tick();
    check("fl_busy", tx_busy, 1);
    base = launches;
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("fl_level", level, 0);
    check("fl_empty", empty, 1);
    check("fl_ovf", overflow, 0);
    repeat (150) tick();
    check("fl_done", tx_busy, 0);
    check("fl_nolaunch", launches - base, 0);

    // Almost-empty on fill and drain
    force_busy = 1'b1;
    check("ae_lvl0", almost_empty, AE_ON);
    for (int i = 0; i < 6; i++) begin
      push(8'h70 + 8'(i));
      check("ae_fill_lvl", level, i + 1);
      check("ae_fill", almost_empty, AE_ON && (i + 1 <= AE));
    end
    hold = 3;
    force_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_start(ok, idle);
      check("ae_drain_lvl", level, 5 - i);
      check("ae_drain", almost_empty, AE_ON && (5 - i <= AE));
    end
    repeat (10) tick();

    // Reset mid-transfer
    hold = 100;
    push(8'h91);
    push(8'h92);
    push(8'h93);
    rst_n = 1'b0;
    tick();
    check("mrst_level", level, 0);
    check("mrst_empty", empty, 1);
    check("mrst_start", tx_start, 0);
    check("mrst_data", tx_data, 0);
    rst_n = 1'b1;
    base = launches;
    repeat (120) tick();
    check("mrst_nolaunch", launches - base, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit-side byte queue that sits directly upstream of the UART core's transmitter. It accepts bytes from the host or register interface into a synchronous FIFO. It launches each byte into the core through the `tx_start`/`tx_data` strobe, one at a time, pacing on the core's `tx_busy` output. This removes the one-byte-at-a-time polling burden from the host and recovers from a core that never acknowledges a launch.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `AE_THRESH`, 4, almost-empty threshold in entries; must be < `DEPTH`
- `ACK_TIMEOUT`, 255, max cycles to wait for `tx_busy` to rise after a launch; ≥ 1
- `clk`  in  1  single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  push strobe; sampled every cycle
- `wr_data`  in  8  byte to push
- `flush`  in  1  discard all queued bytes
- `ovf_clr`  in  1  clears `overflow` and `ack_err`
- `tx_busy`  in  1  busy output of the UART core
- `tx_start`  out  1  one-cycle launch pulse to the core
- `tx_data`  out  8  byte to the core; registered
- `full`  out  1  queue holds `DEPTH` bytes
- `empty`  out  1  queue holds 0 bytes
- `level`  out  $clog2(DEPTH)+1  current fill count
- `almost_empty`  out  1  fill ≤ `AE_THRESH` (see Configuration)
- `overflow`  out  1  sticky: a push was attempted while full
- `ack_err`  out  1  sticky: a launch timed out

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if the queue is not empty and `tx_busy`=0, pop the head into the `tx_data` register and go to LAUNCH. If `tx_busy`=1 in IDLE, stay in IDLE.
- LAUNCH: `tx_start`=1 for exactly this cycle. Load the timeout counter with `ACK_TIMEOUT`. Go to WAIT_BUSY.
- WAIT_BUSY:
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise decrement the counter. On reaching 0, set `ack_err` and go to IDLE; the byte is lost and is not retried.
- WAIT_DONE: when `tx_busy`=0, go to IDLE.
- `tx_data` holds its value from the pop until the next pop.
- Push: accepted when `wr_en`=1 and `full`=0. When `wr_en`=1 and `full`=1, the byte is dropped and `overflow` is set. Push and pop in the same cycle are both honoured, and `level` is unchanged.
- `flush`:
  - Resets both pointers and `level` to 0 on the next edge.
  - Does not abort an in-flight byte; the FSM completes normally.
  - A push in the same cycle is dropped silently (no `overflow`).
  - A flush in IDLE takes priority over a pop in the same cycle.
- `ovf_clr` clears both sticky flags. If a set event coincides with the clear, the set wins.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is a separate counter saturating in the range 0..`DEPTH`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `tx_start`=0, `tx_data`=8'h00.
  - `full`=0, `empty`=1, `level`=0.
  - `almost_empty`=1 when `AE_THRESH` ≥ 0 with the macro defined, else 0.
  - `overflow`=0, `ack_err`=0.
- Reset asserted mid-transfer: the queue empties and the FSM returns to IDLE immediately. The core's in-flight frame is not affected.
- Write-to-launch latency with an empty queue, an idle FSM and `tx_busy`=0:
  - `wr_en` sampled at edge N.
  - Pop at edge N+1.
  - `tx_start` high in the cycle following edge N+1 (2 cycles after the write).
- Back-to-back minimum: the next pop happens 1 cycle after `tx_busy` falls.
- `full`, `empty`, `level` and `almost_empty` are registered and update on the edge after the push or pop.

## Configuration
- `UART_TXQ_AE_IRQ_EN`:
  - Defined: `almost_empty` is a registered compare `level` ≤ `AE_THRESH`, usable as a host refill interrupt.
  - Undefined: `almost_empty` is tied to 0 and the compare logic is absent.
- The port exists in both cases.

## Structure
- `uart_pkg`: FSM state enum `txq_state_t`, the byte width constant `UART_BYTE_W`=8, and default `DEPTH`/`ACK_TIMEOUT` constants.
- Sub-module `uart_sync_fifo`:
  - Parameterised storage, pointers and `level`.
  - Ports: push, pop, flush, full, empty, level.
- `uart_tx_queue` holds the FSM, the timeout counter, the sticky flags and the almost-empty logic.

## Test plan
- Push 0xA5 into an empty queue with an idle core → `tx_start` pulses 2 cycles later with `tx_data`=0xA5; `empty`=1 after the pop.
- Push 0x11, 0x22, 0x33 back-to-back while a core model holds `tx_busy` for 100 cycles per byte → exactly three `tx_start` pulses in order. Each pulse is ≥ 1 cycle after the previous `tx_busy` fall, and `level` steps 3→2→1→0.
- Push 17 bytes with `DEPTH`=16 while `tx_busy`=1 → `full`=1 and `overflow`=1; the 17th byte is never launched. `ovf_clr` clears the flag.
- Core never raises `tx_busy` → after `ACK_TIMEOUT` cycles `ack_err`=1, the FSM returns to IDLE and the next byte launches.
- Queue at 5 with `flush` and `wr_en` asserted together during WAIT_DONE → `level`=0 and `overflow`=0. The in-flight byte completes and no further `tx_start` occurs.
- With `UART_TXQ_AE_IRQ_EN` defined, fill to 6 then drain → `almost_empty` rises on the edge where `level` becomes 4. Without the macro, `almost_empty` stays 0 throughout.
